fast_conv_controller: RTL and testbench
=======================================

Name: fast_conv_controller

Overview:
Front end of the event-driven convolution layer. Buffers incoming spike events (x,y) in an internal input FIFO, pops them one at a time, and expands each event into the in-bounds KERNEL_SIZE x KERNEL_SIZE neighbourhood of feature-map update requests. On a timestep it performs a leak sweep over every feature-map pixel once the FIFO has drained. Sits between the spike source and the feature-map update/output stage.

Parameters:
COORD_BITS, 8, bits per coordinate
IMG_WIDTH, 32, feature-map width
IMG_HEIGHT, 32, feature-map height
CHANNELS, 6, feature-map channels (sets word width only)
BITS_PER_CHANNEL, 6, bits per channel; FM word = CHANNELS*BITS_PER_CHANNEL
KERNEL_SIZE, 3, odd kernel size; R = KERNEL_SIZE/2
FIFO_DATA_WIDTH, 2*COORD_BITS, packed event width
INPUT_FIFO_EVENT_CAPACITY, 16, FIFO depth (power of 2)
INPUT_FIFO_ADDR_WIDTH, clog2(capacity), FIFO pointer width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
sys_enable  in  1  allows FSM to start new work
sys_reset  in  1  synchronous soft clear, same effect as rst
timestep  in  1  single-cycle timestep pulse
spike_event  in  FIFO_DATA_WIDTH  event, {x[upper], y[lower]}
write_enable  in  1  push spike_event
output_fifo_full  in  1  downstream backpressure
system_active  out  1  work pending or in progress
fifo_empty  out  1  input FIFO empty
fifo_full  out  1  input FIFO full
pixel_valid  out  1  update request valid
pixel_coord  out  FIFO_DATA_WIDTH  target pixel {x,y}
pixel_addr  out  clog2(IMG_WIDTH*IMG_HEIGHT)  y*IMG_WIDTH+x
pixel_kidx  out  clog2(KERNEL_SIZE^2)  kernel tap (dy+R)*KERNEL_SIZE+(dx+R)
pixel_leak  out  1  1 = leak-sweep request, 0 = convolution request

Behaviour:
- Reset (rst or sys_reset): FIFO flushed, FSM IDLE, timestep_pending=0; fifo_empty=1, fifo_full=0, system_active=0, pixel_valid=0, other outputs 0.
- FIFO: write_enable and !fifo_full pushes spike_event regardless of sys_enable; write while full is dropped, no state change. Flags derived from an occupancy count (0..capacity); full at capacity. Push+pop same cycle: count unchanged. Pushed event poppable next cycle.
- timestep sets timestep_pending (sticky; repeated pulses merge).
- FSM states IDLE, POP, CONV, SWEEP.
- IDLE: sys_enable and !fifo_empty -> POP (events take priority); else sys_enable and timestep_pending and fifo_empty -> SWEEP, clearing pending.
- POP: one cycle; pop head, latch x,y. x>=IMG_WIDTH or y>=IMG_HEIGHT -> discard, IDLE; else CONV with dy=dx=-R.
- CONV: one tap per cycle, row-major (dy outer, dx inner). Tap (x+dx,y+dy) in bounds -> pixel_valid=1, pixel_leak=0, coord/addr/kidx registered. Out-of-bounds taps consume a cycle with pixel_valid=0. After tap (R,R) -> IDLE.
- SWEEP: pixels y=0..H-1, x=0..W-1, one per cycle, pixel_valid=1, pixel_leak=1, kidx=0; after (W-1,H-1) -> IDLE.
- output_fifo_full=1 in CONV/SWEEP: counters and outputs hold; no taps skipped. Registered outputs; pixel_valid high while held (downstream consumes when full=0).
- sys_enable low only stops new work from IDLE; CONV/SWEEP in progress run to completion.
- system_active = (state!=IDLE) | !fifo_empty | timestep_pending.

Optional Feature:
FAST_CONV_OVERFLOW_FLAG_EN: adds output fifo_overflow (1 bit), sticky high after any write attempted while full, cleared only by rst/sys_reset. Without the macro the port is absent and dropped writes are silent.

Decomposition:
Package snn_interfaces_pkg: vec2_t {x,y} of COORD_BITS each, pack_coordinates/unpack_coordinates ({x,y}, x upper), FSM state enum. Sub-module input_event_fifo (synchronous FIFO, count-based flags) instantiated once.

Test Plan:
- Reset 30 ns, release, sys_enable=1 -> fifo_empty=1, fifo_full=0, system_active=0, pixel_valid=0.
- Write 0x0505 (5,5) -> 9 requests, coords x,y in 4..6 row-major, kidx 0..8, addr of (5,5)=165, leak=0; then system_active=0.
- Write 0x001F (0,31) -> exactly 4 requests (0,30),(1,30),(0,31),(1,31) with kidx 1,2,4,5.
- sys_enable=0, write 20 events -> fifo_full=1 after 16th, 4 dropped (fifo_overflow=1 with macro); enable -> exactly 16 events processed.
- output_fifo_full=1 for 5 cycles mid-CONV -> outputs frozen, no taps lost, 9 total for an interior event.
- timestep with 3 events queued -> all events expanded first, then 1024 leak requests (0,0)..(31,31), timestep_pending cleared, system_active falls after last.

Source files
------------

// File: rtl/snn_interfaces_pkg.sv
// Shared types for the event-driven convolution front end: coordinate vector,
// FSM state encoding and {x,y} pack/unpack helpers (x in the upper half).
package snn_interfaces_pkg;

    localparam int COORD_BITS       = 8;
    localparam int CHANNELS         = 6;
    localparam int BITS_PER_CHANNEL = 6;
    localparam int FM_WORD_WIDTH    = CHANNELS * BITS_PER_CHANNEL;

    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } vec2_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_CONV  = 2'd2,
        ST_SWEEP = 2'd3
    } fsm_state_t;

    function automatic logic [2*COORD_BITS-1:0] pack_coordinates(input vec2_t v);
        return {v.x, v.y};
    endfunction

    function automatic vec2_t unpack_coordinates(input logic [2*COORD_BITS-1:0] d);
        vec2_t v;
        v.x = d[2*COORD_BITS-1:COORD_BITS];
        v.y = d[COORD_BITS-1:0];
        return v;
    endfunction

endpackage

// File: rtl/fast_conv_controller_if.sv
// Bus between spike source / update stage and fast_conv_controller.
// Carries fifo_overflow only when FAST_CONV_OVERFLOW_FLAG_EN is defined.
interface fast_conv_controller_if
    import snn_interfaces_pkg::*;
#(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = 3
) ();
    localparam int FIFO_DATA_WIDTH = 2 * COORD_BITS;
    localparam int ADDR_WIDTH      = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int KIDX_WIDTH      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1;

    logic                       sys_enable;
    logic                       sys_reset;
    logic                       timestep;
    logic [FIFO_DATA_WIDTH-1:0] spike_event;
    logic                       write_enable;
    logic                       output_fifo_full;

    logic                       system_active;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       pixel_valid;
    logic [FIFO_DATA_WIDTH-1:0] pixel_coord;
    logic [ADDR_WIDTH-1:0]      pixel_addr;
    logic [KIDX_WIDTH-1:0]      pixel_kidx;
    logic                       pixel_leak;
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
    logic                       fifo_overflow;
`endif

    modport master (
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
        input  fifo_overflow,
`endif
        output sys_enable, sys_reset, timestep, spike_event, write_enable, output_fifo_full,
        input  system_active, fifo_empty, fifo_full, pixel_valid, pixel_coord,
               pixel_addr, pixel_kidx, pixel_leak
    );

    modport slave (
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
        output fifo_overflow,
`endif
        input  sys_enable, sys_reset, timestep, spike_event, write_enable, output_fifo_full,
        output system_active, fifo_empty, fifo_full, pixel_valid, pixel_coord,
               pixel_addr, pixel_kidx, pixel_leak
    );

endinterface

// File: rtl/input_event_fifo.sv
// Synchronous event FIFO; empty/full come from an occupancy count so that a
// power-of-two depth can be completely filled.
module input_event_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign w_push  = wr_en & ~full;
    assign w_pop   = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{ADDR_WIDTH{1'b0}}, w_push} - {{ADDR_WIDTH{1'b0}}, w_pop};
        end
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fast_conv_controller.sv
// Event-driven convolution front end: queues spike events, expands each into its
// in-bounds kernel neighbourhood, and runs a leak sweep per timestep.
// Optional FAST_CONV_OVERFLOW_FLAG_EN adds a sticky fifo_overflow output.
module fast_conv_controller
    import snn_interfaces_pkg::*;
#(
    parameter int IMG_WIDTH                 = 32,
    parameter int IMG_HEIGHT                = 32,
    parameter int KERNEL_SIZE               = 3,
    parameter int INPUT_FIFO_EVENT_CAPACITY = 16,
    parameter int INPUT_FIFO_ADDR_WIDTH     = $clog2(INPUT_FIFO_EVENT_CAPACITY)
) (
    input  logic                  clk,
    input  logic                  rst,
    fast_conv_controller_if.slave bus
);
    localparam int R   = KERNEL_SIZE / 2;
    localparam int FDW = 2 * COORD_BITS;
    localparam int SW  = COORD_BITS + 1;
    localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int AW  = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int KIW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1;

    localparam logic [SW-1:0]         R_S    = SW'(R);
    localparam logic [SW-1:0]         W_S    = SW'(IMG_WIDTH);
    localparam logic [SW-1:0]         H_S    = SW'(IMG_HEIGHT);
    localparam logic [KW-1:0]         K_LAST = KW'(KERNEL_SIZE - 1);
    localparam logic [KIW-1:0]        K_SIZE = KIW'(KERNEL_SIZE);
    localparam logic [COORD_BITS-1:0] R_C    = COORD_BITS'(R);
    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WIDTH - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HEIGHT - 1);
    localparam logic [AW-1:0]         W_A    = AW'(IMG_WIDTH);

    function automatic logic [AW-1:0] lin_addr(input vec2_t p);
        return AW'(p.y) * W_A + AW'(p.x);
    endfunction

    fsm_state_t     r_state;
    fsm_state_t     w_state_next;
    logic           w_clr;
    logic           w_stall;
    logic           w_fifo_rd;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic [FDW-1:0] w_fifo_dout;
    vec2_t          w_head;
    logic           w_head_ok;

    vec2_t          r_ev;          // latched event, reused as sweep position
    logic [KW-1:0]  r_kx;
    logic [KW-1:0]  r_ky;
    logic           r_pending;
    logic           w_sweep_start;

    logic [SW-1:0]  w_sx;
    logic [SW-1:0]  w_sy;
    logic           w_tap_ok;
    vec2_t          w_tap;
    logic [KIW-1:0] w_kidx;
    logic           w_conv_last;
    logic           w_sweep_last;

    logic           w_out_valid;
    logic           w_out_leak;
    vec2_t          w_out_pos;
    logic [KIW-1:0] w_out_kidx;

    logic           r_pix_valid;
    logic           r_pix_leak;
    vec2_t          r_pix_pos;
    logic [AW-1:0]  r_pix_addr;
    logic [KIW-1:0] r_pix_kidx;

    assign w_clr   = rst | bus.sys_reset;
    assign w_stall = bus.output_fifo_full;

    input_event_fifo #(
        .DATA_WIDTH (FDW),
        .DEPTH      (INPUT_FIFO_EVENT_CAPACITY),
        .ADDR_WIDTH (INPUT_FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (w_clr),
        .wr_en   (bus.write_enable),
        .wr_data (bus.spike_event),
        .rd_en   (w_fifo_rd),
        .rd_data (w_fifo_dout),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    assign w_head    = unpack_coordinates(w_fifo_dout);
    assign w_head_ok = ({1'b0, w_head.x} < W_S) && ({1'b0, w_head.y} < H_S);

    // Kernel offsets are kept biased by +R so bounds checks stay unsigned.
    assign w_sx     = {1'b0, r_ev.x} + SW'(r_kx);
    assign w_sy     = {1'b0, r_ev.y} + SW'(r_ky);
    assign w_tap_ok = (w_sx >= R_S) && ((w_sx - R_S) < W_S) &&
                      (w_sy >= R_S) && ((w_sy - R_S) < H_S);
    assign w_tap.x  = r_ev.x + COORD_BITS'(r_kx) - R_C;
    assign w_tap.y  = r_ev.y + COORD_BITS'(r_ky) - R_C;
    assign w_kidx   = KIW'(r_ky) * K_SIZE + KIW'(r_kx);

    assign w_conv_last   = (r_kx == K_LAST) && (r_ky == K_LAST);
    assign w_sweep_last  = (r_ev.x == X_LAST) && (r_ev.y == Y_LAST);
    assign w_sweep_start = (r_state == ST_IDLE) && (w_state_next == ST_SWEEP);

    always_ff @(posedge clk) begin
        if (rst || bus.sys_reset) r_state <= ST_IDLE;
        else                      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.sys_enable && !w_fifo_empty)   w_state_next = ST_POP;
                else if (bus.sys_enable && r_pending)  w_state_next = ST_SWEEP;
            end
            ST_POP:   w_state_next = w_head_ok ? ST_CONV : ST_IDLE;
            ST_CONV:  if (!w_stall && w_conv_last)  w_state_next = ST_IDLE;
            ST_SWEEP: if (!w_stall && w_sweep_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fifo_rd   = 1'b0;
        w_out_valid = 1'b0;
        w_out_leak  = 1'b0;
        w_out_pos   = '0;
        w_out_kidx  = '0;
        unique case (r_state)
            ST_POP: w_fifo_rd = 1'b1;
            ST_CONV: begin
                w_out_valid = w_tap_ok;
                if (w_tap_ok) begin
                    w_out_pos  = w_tap;
                    w_out_kidx = w_kidx;
                end
            end
            ST_SWEEP: begin
                w_out_valid = 1'b1;
                w_out_leak  = 1'b1;
                w_out_pos   = r_ev;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.sys_reset) begin
            r_ev        <= '0;
            r_kx        <= '0;
            r_ky        <= '0;
            r_pending   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_leak  <= 1'b0;
            r_pix_pos   <= '0;
            r_pix_addr  <= '0;
            r_pix_kidx  <= '0;
        end else begin
            r_pending <= bus.timestep | (r_pending & ~w_sweep_start);
            unique case (r_state)
                ST_IDLE: if (w_sweep_start) r_ev <= '0;
                ST_POP: begin
                    r_ev <= w_head;
                    r_kx <= '0;
                    r_ky <= '0;
                end
                ST_CONV: if (!w_stall) begin
                    if (r_kx == K_LAST) begin
                        r_kx <= '0;
                        r_ky <= r_ky + 1'b1;
                    end else begin
                        r_kx <= r_kx + 1'b1;
                    end
                end
                ST_SWEEP: if (!w_stall) begin
                    if (r_ev.x == X_LAST) begin
                        r_ev.x <= '0;
                        r_ev.y <= r_ev.y + 1'b1;
                    end else begin
                        r_ev.x <= r_ev.x + 1'b1;
                    end
                end
                default: ;
            endcase
            // Presented request is only replaced once downstream can take it.
            if (!w_stall) begin
                r_pix_valid <= w_out_valid;
                r_pix_leak  <= w_out_leak;
                r_pix_pos   <= w_out_pos;
                r_pix_addr  <= lin_addr(w_out_pos);
                r_pix_kidx  <= w_out_kidx;
            end
        end
    end

`ifdef FAST_CONV_OVERFLOW_FLAG_EN
    logic r_overflow;
    always_ff @(posedge clk) begin
        if (rst || bus.sys_reset) r_overflow <= 1'b0;
        else                      r_overflow <= r_overflow | (bus.write_enable & w_fifo_full);
    end
    assign bus.fifo_overflow = r_overflow;
`endif

    assign bus.system_active = (r_state != ST_IDLE) | ~w_fifo_empty | r_pending;
    assign bus.fifo_empty    = w_fifo_empty;
    assign bus.fifo_full     = w_fifo_full;
    assign bus.pixel_valid   = r_pix_valid;
    assign bus.pixel_leak    = r_pix_leak;
    assign bus.pixel_coord   = pack_coordinates(r_pix_pos);
    assign bus.pixel_addr    = r_pix_addr;
    assign bus.pixel_kidx    = r_pix_kidx;

endmodule

// File: tb/tb_fast_conv_controller.sv
// Directed bench for fast_conv_controller: each consumed request is packed as
// {leak, kidx, addr, coord} and compared against a reference list built here.
module tb_fast_conv_controller;
    import snn_interfaces_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    fast_conv_controller_if bus ();
    fast_conv_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input bit leak, input int kidx, input int x, input int y);
        return {1'b0, leak, 4'(kidx), 10'(y * 32 + x), 8'(x), 8'(y)};
    endfunction

    function automatic logic [31:0] cur_word();
        return {1'b0, bus.pixel_leak, bus.pixel_kidx, bus.pixel_addr, bus.pixel_coord};
    endfunction

    function automatic void exp_event(input int x, input int y);
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int tx = x + dx;
                int ty = y + dy;
                if (tx >= 0 && tx < 32 && ty >= 0 && ty < 32)
                    exp_q.push_back(mk_word(1'b0, (dy + 1) * 3 + (dx + 1), tx, ty));
            end
        end
    endfunction

    function automatic void exp_sweep();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                exp_q.push_back(mk_word(1'b1, 0, x, y));
    endfunction

    task automatic write_event(input logic [15:0] ev);
        bus.spike_event  = ev;
        bus.write_enable = 1'b1;
        step();
        bus.write_enable = 1'b0;
    endtask

    // Records every request taken by downstream until the block goes quiet;
    // optionally holds output_fifo_full for 5 cycles after stall_after requests.
    task automatic collect(input int stall_after, input int budget);
        int          cyc        = 0;
        int          stall_left = 0;
        bit          stall_done = 1'b0;
        logic [31:0] frozen     = '0;
        got_q.delete();
        forever begin
            if (!stall_done && stall_after >= 0 && got_q.size() == stall_after && bus.pixel_valid) begin
                bus.output_fifo_full = 1'b1;
                stall_left = 5;
                frozen     = cur_word();
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                chk("stall_valid_held", {31'd0, bus.pixel_valid}, 32'd1);
                chk("stall_outputs_frozen", cur_word(), frozen);
                stall_left--;
            end else begin
                bus.output_fifo_full = 1'b0;
            end
            if (bus.pixel_valid && !bus.output_fifo_full) got_q.push_back(cur_word());
            if (!bus.system_active && !bus.pixel_valid) break;
            if (cyc >= budget) begin
                chk("collect_timeout_active_valid", {30'd0, bus.system_active, bus.pixel_valid}, 32'd0);
                break;
            end
            step();
            cyc++;
        end
        bus.output_fifo_full = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        bus.sys_enable       = 1'b0;
        bus.sys_reset        = 1'b0;
        bus.timestep         = 1'b0;
        bus.spike_event      = '0;
        bus.write_enable     = 1'b0;
        bus.output_fifo_full = 1'b0;

        // Reset state
        #30;
        rst = 1'b0;
        bus.sys_enable = 1'b1;
        #1;
        chk("rst_fifo_empty", {31'd0, bus.fifo_empty}, 32'd1);
        chk("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd0);
        chk("rst_system_active", {31'd0, bus.system_active}, 32'd0);
        chk("rst_pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
        chk("rst_outputs_zero", cur_word(), 32'd0);
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
        chk("rst_overflow", {31'd0, bus.fifo_overflow}, 32'd0);
`endif

        // Interior event (5,5): full 3x3 neighbourhood
        write_event(16'h0505);
        collect(-1, 200);
        exp_q.delete();
        exp_event(5, 5);
        compare_q("interior_5_5");
        if (got_q.size() > 4) chk("center_addr_165", {22'd0, got_q[4][25:16]}, 32'd165);
        chk("interior_active_after", {31'd0, bus.system_active}, 32'd0);

        // Corner event (0,31): only four taps in bounds
        write_event(16'h001F);
        collect(-1, 200);
        exp_q.delete();
        exp_q.push_back(mk_word(1'b0, 1, 0, 30));
        exp_q.push_back(mk_word(1'b0, 2, 1, 30));
        exp_q.push_back(mk_word(1'b0, 4, 0, 31));
        exp_q.push_back(mk_word(1'b0, 5, 1, 31));
        compare_q("corner_0_31");

        // Out-of-range event (32,5) is discarded
        write_event(16'h2005);
        collect(-1, 200);
        exp_q.delete();
        compare_q("discard_32_5");

        // Fill FIFO with enable low: 16 kept, 4 dropped
        bus.sys_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            write_event({8'(3 + i), 8'(20 - i)});
            if (i == 14) chk("fill_not_full_15", {31'd0, bus.fifo_full}, 32'd0);
            if (i == 15) chk("fill_full_16", {31'd0, bus.fifo_full}, 32'd1);
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
            if (i == 15) chk("overflow_before_drop", {31'd0, bus.fifo_overflow}, 32'd0);
`endif
        end
        chk("fill_full_after_20", {31'd0, bus.fifo_full}, 32'd1);
        chk("fill_pixel_idle", {31'd0, bus.pixel_valid}, 32'd0);
`ifdef FAST_CONV_OVERFLOW_FLAG_EN
        chk("overflow_sticky", {31'd0, bus.fifo_overflow}, 32'd1);
`endif
        bus.sys_enable = 1'b1;
        collect(-1, 1000);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_event(3 + i, 20 - i);
        compare_q("fill_16_events");
        chk("fill_empty_after", {31'd0, bus.fifo_empty}, 32'd1);

        // Backpressure for 5 cycles mid-expansion
        write_event(16'h0A0A);
        collect(3, 200);
        exp_q.delete();
        exp_event(10, 10);
        compare_q("stall_10_10");

        // Timestep with 3 queued events: events first, then full leak sweep
        bus.sys_enable = 1'b0;
        write_event(16'h0203);
        write_event(16'h1F1F);
        write_event(16'h0700);
        bus.timestep = 1'b1;
        step();
        bus.timestep = 1'b0;
        step();
        chk("ts_active_while_disabled", {31'd0, bus.system_active}, 32'd1);
        chk("ts_no_request_while_disabled", {31'd0, bus.pixel_valid}, 32'd0);
        bus.sys_enable = 1'b1;
        collect(-1, 3000);
        exp_q.delete();
        exp_event(2, 3);
        exp_event(31, 31);
        exp_event(7, 0);
        exp_sweep();
        compare_q("timestep_sweep");
        chk("ts_active_after_sweep", {31'd0, bus.system_active}, 32'd0);

        // Soft reset flushes queued work and the pending timestep
        bus.sys_enable = 1'b0;
        write_event(16'h0101);
        bus.timestep = 1'b1;
        step();
        bus.timestep = 1'b0;
        chk("sr_active_before", {31'd0, bus.system_active}, 32'd1);
        bus.sys_reset = 1'b1;
        step();
        bus.sys_reset = 1'b0;
        chk("sr_fifo_empty", {31'd0, bus.fifo_empty}, 32'd1);
        chk("sr_system_active", {31'd0, bus.system_active}, 32'd0);
        bus.sys_enable = 1'b1;
        step();
        step();
        step();
        chk("sr_no_sweep", {31'd0, bus.pixel_valid}, 32'd0);
        chk("sr_still_idle", {31'd0, bus.system_active}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
